// File: rtl/fetch_sw_wr.sv
// fetch_sw_wr: search-window cache writer. Per MB it fetches one (or, at the
// start of an MB row, three) 16-pixel luma column strips from the external
// loader and writes them row by row into the free cache bank. After each
// column it rotates the one-hot bank pointer.
// Optional: FETCH_SW_WR_OUTREG_EN registers the cache write port (+1 cycle).

package fetch_sw_wr_pkg;
    // Values mirrored from enc_defines.v
    localparam int PIC_W_MB_LEN = 8;
    localparam int PIC_H_MB_LEN = 8;
    localparam int SW_H_LEN     = 6;
    localparam int MB_WIDTH     = 16;
    localparam int BIT_DEPTH    = 8;
endpackage

module fetch_sw_wr
    import fetch_sw_wr_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PIC_W_MB_LEN-1:0]       sys_total_x,
    input  logic [PIC_H_MB_LEN-1:0]       sys_total_y,
    input  logic                          wr_start_i,
    input  logic [7:0]                    wr_mb_x_i,
    input  logic [7:0]                    wr_mb_y_i,
    output logic                          wr_done_o,
    output logic                          ext_req_o,
    output logic [7:0]                    ext_col_o,
    output logic [11:0]                   ext_row_o,
    output logic [5:0]                    ext_nrow_o,
    input  logic                          ext_ack_i,
    input  logic                          ext_valid_i,
    input  logic [MB_WIDTH*BIT_DEPTH-1:0] ext_data_i,
    output logic [5:0]                    cache_wren_o,
    output logic [SW_H_LEN-1:0]           cache_waddr_o,
    output logic [MB_WIDTH*BIT_DEPTH-1:0] cache_wdata_o,
    output logic [5:0]                    cache_bsel_o
);

    // DRAIN is only entered when the write port is registered
    typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, ADV, DONE} state_t;

    state_t              state, state_nxt;
    logic [7:0]          mb_x_r;
    logic [1:0]          col_idx, last_idx;
    logic                skip;
    logic [7:0]          col_r;
    logic [11:0]         row_r;
    logic [5:0]          nrow_r;
    logic [5:0]          row_cnt;
    logic [SW_H_LEN-1:0] addr_r, addr_base;
    logic [5:0]          bsel_r;
    logic                wr;
    logic                top, bot;
    logic [8:0]          col_first, col_next;

    // Column idx of the strip list: 0,1,2 at row start, else mb_x+2 (9 bits so
    // the skip compare cannot wrap)
    function automatic logic [8:0] col_of(input logic [7:0] mbx, input logic [1:0] idx);
        return (mbx == 8'd0) ? {7'd0, idx} : {1'b0, mbx} + 9'd2;
    endfunction

    assign top       = (wr_mb_y_i == 8'd0);
    assign bot       = (wr_mb_y_i == sys_total_y);
    assign col_first = col_of(wr_mb_x_i, 2'd0);
    assign col_next  = col_of(mb_x_r, col_idx + 2'd1);
    assign wr        = (state == DATA) && ext_valid_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (wr_start_i) state_nxt = REQ;
            REQ:   if (skip) state_nxt = ADV;
                   else if (ext_ack_i) state_nxt = DATA;
`ifdef FETCH_SW_WR_OUTREG_EN
            DATA:  if (wr && row_cnt == nrow_r - 6'd1) state_nxt = DRAIN;
`else
            DATA:  if (wr && row_cnt == nrow_r - 6'd1) state_nxt = ADV;
`endif
            DRAIN: state_nxt = ADV;
            ADV:   state_nxt = (col_idx == last_idx) ? DONE : REQ;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strip capture at REQ entry, row/address counters, bank pointer rotation
    always_ff @(posedge clk) begin
        if (rst) begin
            mb_x_r    <= '0;
            col_idx   <= '0;
            last_idx  <= '0;
            skip      <= 1'b0;
            col_r     <= '0;
            row_r     <= '0;
            nrow_r    <= '0;
            addr_base <= '0;
            row_cnt   <= '0;
            addr_r    <= '0;
            bsel_r    <= 6'b000001;
        end else begin
            case (state)
                IDLE: if (wr_start_i) begin
                    mb_x_r    <= wr_mb_x_i;
                    col_idx   <= 2'd0;
                    last_idx  <= (wr_mb_x_i == 8'd0) ? 2'd2 : 2'd0;
                    col_r     <= col_first[7:0];
                    skip      <= col_first > {1'b0, sys_total_x};
                    row_r     <= {wr_mb_y_i, 4'd0} - (top ? 12'd0 : 12'd16);
                    nrow_r    <= 6'd48 - (top ? 6'd16 : 6'd0) - (bot ? 6'd16 : 6'd0);
                    addr_base <= top ? 6'd16 : 6'd0;
                end
                REQ: begin
                    row_cnt <= '0;
                    addr_r  <= addr_base;
                end
                DATA: if (wr) begin
                    row_cnt <= row_cnt + 6'd1;
                    addr_r  <= addr_r + 6'd1;
                end
                ADV: begin
                    bsel_r <= {bsel_r[4:0], bsel_r[5]};
                    if (col_idx != last_idx) begin
                        col_idx <= col_idx + 2'd1;
                        col_r   <= col_next[7:0];
                        skip    <= col_next > {1'b0, sys_total_x};
                    end
                end
                default: ;
            endcase
        end
    end

    assign ext_req_o    = (state == REQ) && !skip;
    assign wr_done_o    = (state == DONE);
    assign ext_col_o    = col_r;
    assign ext_row_o    = row_r;
    assign ext_nrow_o   = nrow_r;
    assign cache_bsel_o = bsel_r;

`ifdef FETCH_SW_WR_OUTREG_EN
    // Registered cache write port
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_wren_o  <= '0;
            cache_waddr_o <= '0;
            cache_wdata_o <= '0;
        end else begin
            cache_wren_o  <= wr ? bsel_r : 6'd0;
            cache_waddr_o <= wr ? addr_r : '0;
            cache_wdata_o <= wr ? ext_data_i : '0;
        end
    end
`else
    // Combinational cache write port, zero when idle
    always_comb begin
        cache_wren_o  = wr ? bsel_r : 6'd0;
        cache_waddr_o = wr ? addr_r : '0;
        cache_wdata_o = wr ? ext_data_i : '0;
    end
`endif

endmodule
